// File: rtl/sine_q30_cordic_gen.sv
// Iterative CORDIC sine/cosine generator with a 32-bit phase accumulator.
// Each accepted request samples the accumulator, advances it by phase_inc,
// and runs ITER rotation iterations. The result is emitted as signed Q2.30
// sin_out/cos_out together with a one-cycle out_valid strobe.
//
// Ports:
//   clk        sole clock, rising edge
//   aresetn    asynchronous active-low reset
//   en         sample request, taken only while ready=1
//   phase_inc  accumulator step (2^-32 turn units)
//   phase_load synchronous accumulator load, any state
//   phase_init value loaded by phase_load
//   ready      high while IDLE
//   sin_out    Q2.30 sine of the captured phase
//   cos_out    Q2.30 cosine of the captured phase
//   out_valid  one-cycle strobe when sin_out/cos_out update
//
// state  | meaning
// IDLE   | waiting for en; accumulator advances on acceptance
// ROTATE | one CORDIC micro-rotation per cycle, ITER cycles
// DONE   | un-fold the quadrant, register outputs, pulse out_valid
module sine_q30_cordic_gen #(
  parameter int unsigned ITER = 24
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        en,
  input  logic [31:0] phase_inc,
  input  logic        phase_load,
  input  logic [31:0] phase_init,
  output logic        ready,
  output logic [31:0] sin_out,
  output logic [31:0] cos_out,
  output logic        out_valid
);

  localparam logic [31:0] K_Q30     = 32'h26DD3B6A;
  localparam logic [4:0]  LAST_ITER = 5'(ITER - 1);

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

  state_t             state, state_nxt;
  logic [31:0]        phase_acc;
  logic signed [31:0] x_r, y_r, z_r;
  logic [4:0]         iter_r;
  logic               neg_r;

  logic               accept;
  logic               fold;
  logic signed [31:0] x_sh, y_sh, atan_i;

  // atan(2^-i) in 2^-32 turn units
  function automatic logic [31:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:  atan_lut = 32'h20000000;
      5'd1:  atan_lut = 32'h12E4051E;
      5'd2:  atan_lut = 32'h09FB385B;
      5'd3:  atan_lut = 32'h051111D4;
      5'd4:  atan_lut = 32'h028B0D43;
      5'd5:  atan_lut = 32'h0145D7E1;
      5'd6:  atan_lut = 32'h00A2F61E;
      5'd7:  atan_lut = 32'h00517C55;
      5'd8:  atan_lut = 32'h0028BE53;
      5'd9:  atan_lut = 32'h00145F2F;
      5'd10: atan_lut = 32'h000A2F98;
      5'd11: atan_lut = 32'h000517CC;
      5'd12: atan_lut = 32'h00028BE6;
      5'd13: atan_lut = 32'h000145F3;
      5'd14: atan_lut = 32'h0000A2FA;
      5'd15: atan_lut = 32'h0000517D;
      5'd16: atan_lut = 32'h000028BE;
      5'd17: atan_lut = 32'h0000145F;
      5'd18: atan_lut = 32'h00000A30;
      5'd19: atan_lut = 32'h00000518;
      5'd20: atan_lut = 32'h0000028C;
      5'd21: atan_lut = 32'h00000146;
      5'd22: atan_lut = 32'h000000A3;
      5'd23: atan_lut = 32'h00000051;
      5'd24: atan_lut = 32'h00000029;
      5'd25: atan_lut = 32'h00000014;
      5'd26: atan_lut = 32'h0000000A;
      5'd27: atan_lut = 32'h00000005;
      5'd28: atan_lut = 32'h00000003;
      5'd29: atan_lut = 32'h00000001;
      default: atan_lut = 32'h00000000;
    endcase
  endfunction

  assign ready  = (state == IDLE);
  assign accept = (state == IDLE) && en;
  // Quadrants 1 and 2 are rotated by half a turn into [-pi/2, pi/2);
  // the result is negated again on the way out.
  assign fold   = phase_acc[31] ^ phase_acc[30];
  assign x_sh   = x_r >>> iter_r;
  assign y_sh   = y_r >>> iter_r;
  assign atan_i = $signed(atan_lut(iter_r));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = ROTATE;
      ROTATE:  if (iter_r == LAST_ITER) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Load takes priority, but an acceptance in the same cycle has already
  // captured the old accumulator value in the datapath below.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)        phase_acc <= '0;
    else if (phase_load) phase_acc <= phase_init;
    else if (accept)     phase_acc <= phase_acc + phase_inc;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      iter_r <= '0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_r    <= $signed(K_Q30);
            y_r    <= '0;
            z_r    <= fold ? $signed(phase_acc - 32'h80000000) : $signed(phase_acc);
            neg_r  <= fold;
            iter_r <= '0;
          end
        end
        ROTATE: begin
          if (!z_r[31]) begin
            x_r <= x_r - y_sh;
            y_r <= y_r + x_sh;
            z_r <= z_r - atan_i;
          end else begin
            x_r <= x_r + y_sh;
            y_r <= y_r - x_sh;
            z_r <= z_r + atan_i;
          end
          iter_r <= iter_r + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sin_out   <= '0;
      cos_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state == DONE);
      if (state == DONE) begin
        sin_out <= neg_r ? -y_r : y_r;
        cos_out <= neg_r ? -x_r : x_r;
      end
    end
  end

endmodule

// File: tb/tb_sine_q30_cordic_gen.sv
module tb_sine_q30_cordic_gen;

  localparam int ITER = 24;
  localparam int TOL  = 256;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        en = 1'b0;
  logic [31:0] phase_inc = '0;
  logic        phase_load = 1'b0;
  logic [31:0] phase_init = '0;
  logic        ready;
  logic [31:0] sin_out;
  logic [31:0] cos_out;
  logic        out_valid;

  sine_q30_cordic_gen #(.ITER(ITER)) dut (
    .clk(clk), .aresetn(aresetn), .en(en), .phase_inc(phase_inc),
    .phase_load(phase_load), .phase_init(phase_init), .ready(ready),
    .sin_out(sin_out), .cos_out(cos_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] p;
    longint      due;
  } exp_t;

  exp_t        exp_q[$];
  longint      cyc = 0;
  longint      m_free = 0;
  logic [31:0] m_acc = '0;
  bit          m_accept;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_valid = 0;
  longint      last_valid = -1;
  bit          held_run = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_tol(input string name, input longint act, input longint exp);
    longint d;
    d = act - exp;
    if (d < 0) d = -d;
    n_checks++;
    if (d > TOL) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d +-%0d (cycle %0d)", name, act, exp, TOL, cyc);
    end
  endtask

  // Reference model: accumulator, busy window and expected samples.
  // cyc counts active-clock edges seen out of reset.
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_acc  = '0;
      m_free = 0;
      exp_q.delete();
    end else begin
      m_accept = en && (cyc >= m_free);
      if (m_accept) begin
        exp_q.push_back('{p: m_acc, due: cyc + ITER + 2});
        m_free = cyc + ITER + 2;
      end
      if (phase_load)    m_acc = phase_init;
      else if (m_accept) m_acc = m_acc + phase_inc;
      cyc++;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t   e;
    real    ang;
    longint es, ec;
    if (aresetn) begin
      chk("ready", longint'(ready), longint'(cyc >= m_free));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("stray_valid", longint'(out_valid), 0);
        end else begin
          e   = exp_q.pop_front();
          ang = 2.0 * 3.14159265358979323846 * real'(e.p) / 4294967296.0;
          es  = longint'($sin(ang) * 1073741824.0);
          ec  = longint'($cos(ang) * 1073741824.0);
          chk("latency", cyc, e.due);
          chk_tol("sin_out", longint'($signed(sin_out)), es);
          chk_tol("cos_out", longint'($signed(cos_out)), ec);
          if (held_run && last_valid >= 0) chk("period", cyc - last_valid, ITER + 2);
          last_valid = cyc;
          n_valid++;
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        chk("missing_valid", longint'(out_valid), 1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() > 0 || cyc < m_free) && n < 200) begin
      step();
      n++;
    end
    chk("drain_timeout", longint'(n < 200), 1);
  endtask

  task automatic pulse_en();
    en = 1'b1;
    step();
    en = 1'b0;
  endtask

  task automatic request(input logic [31:0] ph);
    phase_load = 1'b1;
    phase_init = ph;
    step();
    phase_load = 1'b0;
    pulse_en();
    wait_idle();
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", longint'(ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_sin", longint'(sin_out), 0);
    chk("rst_cos", longint'(cos_out), 0);
    aresetn = 1'b1;
    step();

    // accumulator comes out of reset at zero
    phase_inc = 32'h10000000;
    pulse_en();
    wait_idle();

    request(32'h00000000);
    request(32'h20000000);
    request(32'h40000000);
    request(32'hC0000000);
    request(32'h80000000);
    request(32'hE0000000);
    request(32'h7FFFFFFF);

    // load and acceptance in the same edge: sample uses the old accumulator
    phase_inc  = $urandom;
    phase_load = 1'b1;
    phase_init = 32'h55555555;
    en         = 1'b1;
    step();
    phase_load = 1'b0;
    en         = 1'b0;
    wait_idle();
    pulse_en();
    wait_idle();

    // random phases, increments and requests while busy
    for (int k = 0; k < 40; k++) begin
      phase_inc = $urandom;
      if ($urandom_range(0, 9) < 3) begin
        phase_load = 1'b1;
        phase_init = $urandom;
      end
      en = 1'b1;
      step();
      phase_load = 1'b0;
      en = 1'b0;
      for (int j = 0; j < 4; j++) begin
        repeat ($urandom_range(1, 5)) step();
        en = 1'b1;
        step();
        en = 1'b0;
      end
      wait_idle();
    end

    // back-to-back samples with en held high
    phase_load = 1'b1;
    phase_init = 32'h0;
    phase_inc  = 32'h01000000;
    step();
    phase_load = 1'b0;
    held_run   = 1'b1;
    last_valid = -1;
    start      = n_valid;
    n          = 0;
    en         = 1'b1;
    while (n_valid < start + 300 && n < 300 * (ITER + 2) + 200) begin
      step();
      n++;
    end
    en = 1'b0;
    chk("held_run_count", longint'(n_valid - start >= 300), 1);
    wait_idle();
    held_run = 1'b0;

    // reset in the middle of a rotation
    phase_load = 1'b1;
    phase_init = 32'h30000000;
    step();
    phase_load = 1'b0;
    pulse_en();
    repeat (8) step();
    #2;
    aresetn = 1'b0;
    #1;
    chk("midrst_sin", longint'(sin_out), 0);
    chk("midrst_cos", longint'(cos_out), 0);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_ready", longint'(ready), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_hold_valid", longint'(out_valid), 0);
    aresetn = 1'b1;
    repeat (ITER + 6) step();
    pulse_en();
    wait_idle();
    request(32'h60000000);

    repeat (3) step();
    summary();
    $finish;
  end

endmodule
